// File: rtl/adder8_serial_ctrl.sv
// adder8_serial_ctrl
//   Sequences one NBYTES-wide addition through an external combinational
//   8-bit adder (adder8), one byte per clock, least significant byte first.
//   The carry is chained between cycles.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready operand handshake; req_a, req_b (W bits), req_cin
//   res_valid/res_ready result handshake; res_sum (W bits), res_cout
//   add_a/add_b/add_cin operands driven to adder8 (zero when not running)
//   add_sum/add_cout    adder8 result, sampled in the cycle it is driven
//   busy                high while an operation is running or awaiting pickup
module adder8_serial_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  input  logic                  req_cin,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*NBYTES-1:0]   res_sum,
  output logic                  res_cout,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  output logic                  busy
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q,   idx_d;
  logic            carry_q, carry_d;
  logic            cout_q,  cout_d;
  logic [W-1:0]    a_q,     a_d;
  logic [W-1:0]    b_q,     b_d;
  logic [W-1:0]    sum_q,   sum_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    req_ready = 1'b0;
    res_valid = 1'b0;
    res_sum   = '0;
    res_cout  = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    busy      = 1'b1;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          carry_d = req_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        add_a   = a_q[8*idx_q +: 8];
        add_b   = b_q[8*idx_q +: 8];
        add_cin = carry_q;
        sum_d[8*idx_q +: 8] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST) begin
          cout_d  = add_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        // Result is exposed only here so partial sums never reach the port.
        res_valid = 1'b1;
        res_sum   = sum_q;
        res_cout  = cout_q;
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/adder8_serial_ctrl.md
Name: adder8_serial_ctrl

Overview:
- Sequencer that time-multiplexes the single combinational 8-bit adder (adder8) to perform one NBYTES-wide addition, one byte per clock.
- Drives the adder operand ports and chains the carry between cycles.
- Requesters present wide operands through a valid/ready handshake and collect the wide sum and carry-out through a second valid/ready handshake.
- Sits between the request source and the adder8 instance; adder8 is instantiated outside this block.

Parameters:
- NBYTES, 4, number of byte lanes per operation; W = 8*NBYTES; legal range 1..16.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request operands valid.
- req_ready  out  1  block can accept a request.
- req_a  in  W  operand A.
- req_b  in  W  operand B.
- req_cin  in  1  carry-in to byte 0.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_sum  out  W  wide sum.
- res_cout  out  1  carry-out of top byte.
- add_a  out  8  to adder8 A.
- add_b  out  8  to adder8 B.
- add_cin  out  1  to adder8 cin.
- add_sum  in  8  from adder8 sum.
- add_cout  in  1  from adder8 cout.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0, carry=0.
  - Operand, sum and carry registers cleared.
  - Outputs: req_ready=1, res_valid=0, res_sum=0, res_cout=0, add_a=0, add_b=0, add_cin=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a rising edge: latch req_a, req_b into a_reg, b_reg; carry<=req_cin; idx<=0; state->RUN.
- RUN:
  - req_ready=0.
  - Combinational drive: add_a=a_reg[8*idx+:8], add_b=b_reg[8*idx+:8], add_cin=carry.
  - Each edge: sum_reg[8*idx+:8]<=add_sum; carry<=add_cout.
  - If idx==NBYTES-1: res_cout<=add_cout and state->DONE; else idx<=idx+1.
- DONE:
  - res_valid=1; res_sum=sum_reg; res_cout held.
  - Both outputs stay stable while res_ready=0.
  - On res_ready=1 at an edge: state->IDLE, res_valid falls.
- add_a, add_b and add_cin are 0 in IDLE and DONE.
- Latency: accept edge to res_valid high = NBYTES clock cycles. Minimum throughput: one op per NBYTES+2 cycles.
- req_ready is high only in IDLE; there is no accept in the same cycle as a result handshake.
- Width rules:
  - Sum is modulo 2^W; res_cout = carry out of bit W-1.
  - The adder is purely combinational, so add_sum is sampled the same cycle it is driven.
- Boundary conditions:
  - req_valid while busy: ignored. The requester must hold its values until req_ready.
  - req_a/req_b changing during RUN: no effect; operands are latched.
  - NBYTES=1: single RUN cycle.
  - rst asserted mid-RUN or in DONE: in-flight operation discarded, reset values immediate; no partial result escapes.
  - res_ready high in IDLE/RUN: ignored.

Test Plan:
- NBYTES=4, A=0xFFFFFFFF, B=0, cin=1 -> carry ripples over all 4 bytes; res_sum=0x00000000, res_cout=1; res_valid exactly 4 cycles after accept; add_cin=1 on every RUN cycle.
- A=0x000000FF, B=0x00000001, cin=0 -> res_sum=0x00000100, res_cout=0; per-cycle add_a sequence FF,00,00,00 and add_cin sequence 0,1,0,0.
- A=0xFFFFFFFF, B=0xFFFFFFFF, cin=0 -> res_sum=0xFFFFFFFE, res_cout=1. Then hold res_ready=0 for 5 cycles -> res_valid, res_sum, res_cout stable and req_ready=0 throughout.
- Back-to-back: (0x12345678 + 0x11111111, cin=0) then (0x000000FF + 0xFFFFFF00, cin=1) with res_ready tied 1 -> results 0x23456789/cout 0 and 0x00000000/cout 1; second req_ready rise exactly 1 cycle after the first result handshake.
- Assert rst for 1 cycle during RUN idx=2 -> res_valid never asserts for that op; outputs return to reset values asynchronously. A fresh request A=1, B=1 then completes with res_sum=2, res_cout=0.
- NBYTES=1, A=0xFF, B=0x01, cin=0 -> res_sum=0x00, res_cout=1 one cycle after accept.
